// File: rtl/des10_pkg.sv
// des10_pkg: shared definitions for the 1:10 fabric deserializer.
// Holds the alignment FSM state type plus the word width and training
// pattern that the OSER10 loopback top also uses to build its transmitter.
package des10_pkg;

  localparam int              DES10_WIDTH     = 10;
  localparam logic [9:0]      DES10_TRAIN_PAT = 10'h2AA;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } des10_state_t;

endpackage

// File: rtl/des10_align_fsm.sv
// des10_align_fsm: word-alignment state machine for des10_rx.
// Compares each valid word against the training pattern while train_i=1,
// counts consecutive matches, requests bit-slips while hunting and reports
// lock. Optional mismatch counter when DES10_ERRCNT_EN is defined.
//
// Ports:
//   clk_i      in   bit clock
//   nrst_i     in   synchronous active-low reset
//   word_i     in   WIDTH  word from the deserializer
//   valid_i    in   1      word_i is new this cycle
//   train_i    in   1      sender is transmitting TRAIN_PAT
//   slip_o     out  1      registered slip pulse; the top holds its bit
//                          counter for exactly this cycle
//   locked_o   out  1      alignment achieved (sticky until reset)
//   err_cnt_o  out  8      saturating mismatch count in LOCKED
//                          (only with DES10_ERRCNT_EN)
module des10_align_fsm
  import des10_pkg::*;
#(
  parameter int               WIDTH      = DES10_WIDTH,
  parameter logic [WIDTH-1:0] TRAIN_PAT  = DES10_TRAIN_PAT,
  parameter int               LOCK_COUNT = 4
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             valid_i,
  input  logic             train_i,
`ifdef DES10_ERRCNT_EN
  output logic [7:0]       err_cnt_o,
`endif
  output logic             slip_o,
  output logic             locked_o
);

  des10_state_t state_q;
  logic [3:0]   match_cnt_q;
  logic         slip_q;
  logic         locked_q;
  logic         match;
  logic [3:0]   match_cnt_inc;

  assign match         = (word_i == TRAIN_PAT);
  assign match_cnt_inc = match_cnt_q + 4'd1;

`ifdef DES10_ERRCNT_EN
  logic [7:0] err_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q     <= HUNT;
      match_cnt_q <= 4'd0;
      slip_q      <= 1'b0;
      locked_q    <= 1'b0;
`ifdef DES10_ERRCNT_EN
      err_cnt_q   <= 8'd0;
`endif
    end else begin
      // The slip request is registered off the valid cycle, so it is
      // applied one cycle later and never coincides with a word boundary.
      slip_q <= 1'b0;
      if (valid_i && train_i) begin
        case (state_q)
          HUNT: begin
            if (match) begin
              if (LOCK_COUNT == 1) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                state_q <= CONFIRM;
              end
              match_cnt_q <= 4'd1;
            end else begin
              slip_q <= 1'b1;
            end
          end
          CONFIRM: begin
            if (match) begin
              match_cnt_q <= match_cnt_inc;
              if (match_cnt_inc == 4'(LOCK_COUNT)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              // Drop back without slipping: the boundary was right at least once.
              state_q     <= HUNT;
              match_cnt_q <= 4'd0;
            end
          end
          LOCKED: begin
`ifdef DES10_ERRCNT_EN
            if (!match && (err_cnt_q != 8'hFF)) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
`endif
          end
          default: begin
            state_q     <= HUNT;
            match_cnt_q <= 4'd0;
          end
        endcase
      end
    end
  end

  assign slip_o   = slip_q;
  assign locked_o = locked_q;

endmodule

// File: rtl/des10_rx.sv
// des10_rx: fabric-level 1:10 deserializer with training-pattern alignment.
// Samples d_i on every rising clk_i edge, assembles WIDTH-bit words (first
// bit received in bit 0) and bit-slips the word boundary until TRAIN_PAT is
// seen LOCK_COUNT times in a row.
// Optional feature macro: DES10_ERRCNT_EN adds err_cnt_o.
//
// Ports:
//   clk_i      in   1      fast bit clock (only clock)
//   nrst_i     in   1      synchronous active-low reset
//   d_i        in   1      serial data
//   train_i    in   1      1 = sender transmits TRAIN_PAT, alignment active
//   word_o     out  WIDTH  assembled word, bit 0 oldest
//   valid_o    out  1      one-cycle strobe for a new word_o
//   locked_o   out  1      alignment achieved
//   slip_o     out  1      one-cycle pulse on each bit-slip
//   err_cnt_o  out  8      mismatches seen while locked (DES10_ERRCNT_EN)
module des10_rx
  import des10_pkg::*;
#(
  parameter int               WIDTH      = DES10_WIDTH,
  parameter logic [WIDTH-1:0] TRAIN_PAT  = DES10_TRAIN_PAT,
  parameter int               LOCK_COUNT = 4
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             d_i,
  input  logic             train_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             locked_o,
`ifdef DES10_ERRCNT_EN
  output logic [7:0]       err_cnt_o,
`endif
  output logic             slip_o
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Only the newest WIDTH-1 bits need storing; the current d_i completes a word.
  logic [WIDTH-1:1] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;
  logic [WIDTH-1:0] word_q;
  logic             valid_q;
  logic             slip;

  assign sr_d = {d_i, sr_q};

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (bit_cnt_q == LAST) begin
      bit_cnt_d = '0;
    end else if (!slip) begin
      // A slip holds the count one cycle, pushing the boundary one bit later.
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      sr_q      <= sr_d[WIDTH-1:1];
      bit_cnt_q <= bit_cnt_d;
      valid_q   <= (bit_cnt_q == LAST);
      if (bit_cnt_q == LAST) begin
        word_q <= sr_d;
      end
    end
  end

  des10_align_fsm #(
    .WIDTH      (WIDTH),
    .TRAIN_PAT  (TRAIN_PAT),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_align (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .word_i    (word_q),
    .valid_i   (valid_q),
    .train_i   (train_i),
`ifdef DES10_ERRCNT_EN
    .err_cnt_o (err_cnt_o),
`endif
    .slip_o    (slip),
    .locked_o  (locked_o)
  );

  assign word_o  = word_q;
  assign valid_o = valid_q;
  assign slip_o  = slip;

endmodule
